gate_resp_checker: RTL

- Synthesizable response-side checker for 2-input gate DUTs such as nor_1b.
- Consumes the per-vector sample (x, y, DUT output o) that a stimulus source presents and compares o against a reference function chosen by op.
- Tracks input-space coverage, counts vectors and mismatches, and captures the first failing vector.
- Reports a pass/fail verdict, replacing eyeball inspection of $monitor output.

---
 rtl/gate_resp_checker_pkg.sv | 31 +++
 rtl/gate_ref_model.sv | 36 +++
 rtl/gate_resp_checker.sv | 131 +++++++++++++
 3 files changed

// File: rtl/gate_resp_checker_pkg.sv
// ============================================================================
// Module      : gate_chk_defs (package)
// Description : Shared op codes, FSM state encodings and coverage constant for
//               the 2-input gate response checker and its reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gate_chk_defs;

    // Reference function selectors
    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_BUF  = 3'd7;

    // Checker FSM encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // All four {y,x} input combinations observed
    localparam logic [3:0] COV_FULL = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/gate_ref_model.sv
// ============================================================================
// Module      : gate_ref_model
// Description : Purely combinational golden model of a 2-input gate selected
//               by op. NOT/BUF ops act on x only.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_ref_model
    import gate_chk_defs::*;
(
    input  logic [2:0] op,
    input  logic       x,
    input  logic       y,
    output logic       expected
);

    // Evaluate the selected reference function
    always_comb begin
        expected = 1'b0;
        case (op)
            OP_AND:  expected = x & y;
            OP_OR:   expected = x | y;
            OP_NAND: expected = ~(x & y);
            OP_NOR:  expected = ~(x | y);
            OP_XOR:  expected = x ^ y;
            OP_XNOR: expected = ~(x ^ y);
            OP_NOT:  expected = ~x;
            OP_BUF:  expected = x;
            default: expected = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/gate_resp_checker.sv
// ============================================================================
// Module      : gate_resp_checker
// Description : Response-side checker for 2-input gate DUTs. Compares each
//               accepted (x, y, o) sample against a reference gate, tracks
//               {y,x} coverage, counts vectors/mismatches (saturating) and
//               captures the first failing vector.
//               Build option GATE_CHK_HALT_EN: stop checking (go to DONE) on
//               the first mismatch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_resp_checker
    import gate_chk_defs::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [2:0]       op,
    input  logic             in_valid,
    input  logic             x,
    input  logic             y,
    input  logic             o,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       coverage,
    output logic [2:0]       fail_vec,
    output logic             fail_seen
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0] state;
    logic [1:0] state_next;
    logic [2:0] op_latched;
    logic       expected;
    logic       accept;
    logic       mismatch;
    logic [3:0] cov_next;

    gate_ref_model u_ref (
        .op       (op_latched),
        .x        (x),
        .y        (y),
        .expected (expected)
    );

    // A start pulse always takes priority, so a sample in its cycle is dropped
    assign accept   = (state == ST_CHECK) && in_valid && !start;
    assign mismatch = accept && (o != expected);
    assign cov_next = coverage | (accept ? (4'b0001 << {y, x}) : 4'b0000);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start wins over stop; CHECK ends on stop or full coverage
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = ST_CHECK;
        end else if (state == ST_CHECK) begin
`ifdef GATE_CHK_HALT_EN
            if (stop || (cov_next == COV_FULL) || mismatch) begin
                state_next = ST_DONE;
            end
`else
            if (stop || (cov_next == COV_FULL)) begin
                state_next = ST_DONE;
            end
`endif
        end
    end

    // Status outputs decoded from the registered state
    always_comb begin
        busy = (state == ST_CHECK);
        done = (state == ST_DONE);
    end

    // Result datapath: clear on start, update on each accepted sample
    always_ff @(posedge clk) begin
        if (rst) begin
            op_latched <= OP_AND;
            vec_cnt    <= '0;
            err_cnt    <= '0;
            coverage   <= 4'b0000;
            fail_vec   <= 3'b000;
            fail_seen  <= 1'b0;
        end else if (start) begin
            op_latched <= op;
            vec_cnt    <= '0;
            err_cnt    <= '0;
            coverage   <= 4'b0000;
            fail_vec   <= 3'b000;
            fail_seen  <= 1'b0;
        end else if (accept) begin
            coverage <= cov_next;
            if (vec_cnt != CNT_MAX) begin
                vec_cnt <= vec_cnt + CNT_ONE;
            end
            if (mismatch) begin
                if (err_cnt != CNT_MAX) begin
                    err_cnt <= err_cnt + CNT_ONE;
                end
                if (!fail_seen) begin
                    fail_vec  <= {x, y, o};
                    fail_seen <= 1'b1;
                end
            end
        end
    end

    // Verdict is only meaningful while done is high
    assign pass = (err_cnt == '0) && (coverage == COV_FULL);

endmodule

`default_nettype wire
